// File: rtl/ysyx_25030093_pkg.sv
// rtl/ysyx_25030093_pkg.sv - shared IFU/PC-stage types and constants
package ysyx_25030093_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } ifu_state_t;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h3000_0000;

endpackage

// File: rtl/ysyx_25030093_ifu_perf.sv
// rtl/ysyx_25030093_ifu_perf.sv - fetch and bus-stall counters, built only with YSYX_25030093_IFU_PERF_EN
module ysyx_25030093_ifu_perf (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_done,
  input  logic        ar_stall,
  input  logic        r_stall,
  output logic [63:0] perf_fetch,
  output logic [63:0] perf_ar_stall,
  output logic [63:0] perf_r_stall
);

  logic [63:0] fetch_q, fetch_d;
  logic [63:0] ar_q, ar_d;
  logic [63:0] r_q, r_d;

  // Each counter advances by one on its qualifying event.
  always_comb begin
    fetch_d = fetch_q + {63'd0, fetch_done};
    ar_d    = ar_q + {63'd0, ar_stall};
    r_d     = r_q + {63'd0, r_stall};
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_q <= '0;
      ar_q    <= '0;
      r_q     <= '0;
    end else begin
      fetch_q <= fetch_d;
      ar_q    <= ar_d;
      r_q     <= r_d;
    end
  end

  assign perf_fetch    = fetch_q;
  assign perf_ar_stall = ar_q;
  assign perf_r_stall  = r_q;

endmodule

// File: rtl/ysyx_25030093_ifu.sv
// rtl/ysyx_25030093_ifu.sv - instruction fetch unit (AXI4-Lite read); perf counters under YSYX_25030093_IFU_PERF_EN
module ysyx_25030093_ifu
  import ysyx_25030093_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              in_valid_pc,
  output logic              busy,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              inst_fault,
  output logic              out_valid,
  input  logic              out_ready
`ifdef YSYX_25030093_IFU_PERF_EN
  ,
  output logic [63:0]       perf_fetch,
  output logic [63:0]       perf_ar_stall,
  output logic [63:0]       perf_r_stall
`endif
);

  ifu_state_t        state_q, state_d;
  logic              boot_pending_q, boot_pending_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [31:0]       out_inst_q, out_inst_d;
  logic              inst_fault_q, inst_fault_d;
  logic              aligned;

  assign aligned = (fetch_pc_q[1:0] == 2'b00);

  // Next-state logic. The alignment check runs on the registered fetch_pc in
  // the cycle after the latch; a misaligned PC never raises arvalid and goes
  // straight to HOLD as a fault with a zero instruction.
  always_comb begin
    state_d        = state_q;
    boot_pending_d = boot_pending_q;
    fetch_pc_d     = fetch_pc_q;
    out_inst_d     = out_inst_q;
    inst_fault_d   = inst_fault_q;
    case (state_q)
      IDLE: begin
        if (boot_pending_q) begin
          fetch_pc_d     = RESET_PC;
          boot_pending_d = 1'b0;
          state_d        = ADDR;
        end else if (in_valid_pc) begin
          fetch_pc_d = pc;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        if (!aligned) begin
          out_inst_d   = '0;
          inst_fault_d = 1'b1;
          state_d      = HOLD;
        end else if (arready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (rvalid) begin
          out_inst_d   = rdata;
          inst_fault_d = (rresp != RESP_OKAY);
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset re-arms the boot fetch.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      boot_pending_q <= 1'b1;
      fetch_pc_q     <= RESET_PC;
      out_inst_q     <= '0;
      inst_fault_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      boot_pending_q <= boot_pending_d;
      fetch_pc_q     <= fetch_pc_d;
      out_inst_q     <= out_inst_d;
      inst_fault_q   <= inst_fault_d;
    end
  end

  // Handshake outputs are masked by reset so a response arriving while reset
  // is held is never accepted.
  assign arvalid    = !reset && (state_q == ADDR) && aligned;
  assign rready     = !reset && (state_q == DATA);
  assign out_valid  = !reset && (state_q == HOLD);
  assign busy       = !reset && (state_q != IDLE);
  assign araddr     = fetch_pc_q;
  assign out_pc     = fetch_pc_q;
  assign out_inst   = out_inst_q;
  assign inst_fault = inst_fault_q;

`ifdef YSYX_25030093_IFU_PERF_EN
  ysyx_25030093_ifu_perf u_perf (
    .clock         (clock),
    .reset         (reset),
    .fetch_done    (out_valid && out_ready),
    .ar_stall      (arvalid && !arready),
    .r_stall       (rready && !rvalid),
    .perf_fetch    (perf_fetch),
    .perf_ar_stall (perf_ar_stall),
    .perf_r_stall  (perf_r_stall)
  );
`endif

endmodule

// File: tb/tb_ysyx_25030093_ifu.sv
// tb/tb_ysyx_25030093_ifu.sv - self-checking bench for ysyx_25030093_ifu
module tb_ysyx_25030093_ifu;

  localparam logic [31:0] BOOT_PC = 32'h3000_0000;

  logic        clock, reset;
  logic [31:0] pc;
  logic        in_valid_pc, busy;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic [31:0] out_inst, out_pc;
  logic        inst_fault, out_valid, out_ready;
`ifdef YSYX_25030093_IFU_PERF_EN
  logic [63:0] perf_fetch, perf_ar_stall, perf_r_stall;
  longint      exp_fetch, exp_ar, exp_r;
`endif

  int n_checks;
  int n_errors;

  ysyx_25030093_ifu dut (
    .clock       (clock),
    .reset       (reset),
    .pc          (pc),
    .in_valid_pc (in_valid_pc),
    .busy        (busy),
    .araddr      (araddr),
    .arvalid     (arvalid),
    .arready     (arready),
    .rdata       (rdata),
    .rresp       (rresp),
    .rvalid      (rvalid),
    .rready      (rready),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .inst_fault  (inst_fault),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
`ifdef YSYX_25030093_IFU_PERF_EN
    ,
    .perf_fetch    (perf_fetch),
    .perf_ar_stall (perf_ar_stall),
    .perf_r_stall  (perf_r_stall)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One fetch as seen from the PC stage and an AXI slave with chosen waits.
  // Expectations come from the latency rule: 3 + waits, or 2 when misaligned.
  task automatic run_fetch(input bit boot, input logic [31:0] p, input int ar_wait,
                           input int r_wait, input logic [1:0] resp,
                           input logic [31:0] data, input int hold_wait);
    logic [31:0] exp_pc, exp_inst;
    bit          mis, got;
    int          exp_lat, cyc, ar_seen, ar_xfers, r_seen;
    exp_pc   = boot ? BOOT_PC : p;
    mis      = (exp_pc[1:0] != 2'b00);
    exp_lat  = mis ? 2 : 3 + ar_wait + r_wait;
    exp_inst = mis ? 32'h0 : data;
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);
    chk("idle_arvalid", arvalid, 0);
    if (boot) begin
      chk("rst_araddr", araddr, BOOT_PC);
      chk("rst_out_pc", out_pc, BOOT_PC);
      chk("rst_inst", out_inst, 0);
      chk("rst_fault", inst_fault, 0);
      chk("rst_rready", rready, 0);
    end
    reset       = 1'b0;
    in_valid_pc = 1'b1;
    pc          = p;
    arready     = 1'b0;
    rvalid      = 1'b0;
    out_ready   = 1'b0;
    ar_seen = 0; ar_xfers = 0; r_seen = 0; got = 0; cyc = 0;
    while (!got && cyc < 40) begin
      step();
      cyc++;
      in_valid_pc = 1'b0;
      arready     = 1'b0;
      rvalid      = 1'b0;
      rdata       = $urandom;
      rresp       = 2'($urandom_range(0, 3));
      if (arvalid) begin
        chk("araddr", araddr, exp_pc);
        if (ar_seen == ar_wait) begin
          arready = 1'b1;
          ar_xfers++;
        end
        ar_seen++;
      end
      if (rready) begin
        if (r_seen == r_wait) begin
          rvalid = 1'b1;
          rdata  = data;
          rresp  = resp;
        end
        r_seen++;
      end
      if (out_valid) got = 1;
    end
    chk("latency", cyc, exp_lat);
    chk("ar_xfers", ar_xfers, mis ? 0 : 1);
    chk("out_inst", out_inst, exp_inst);
    chk("out_pc", out_pc, exp_pc);
    chk("fault", inst_fault, mis || (resp != 2'b00));
    if (hold_wait > 0) begin
      in_valid_pc = 1'b1;
      pc          = $urandom & 32'hffff_fffc;
    end
    for (int i = 0; i < hold_wait; i++) begin
      step();
      in_valid_pc = 1'b0;
      chk("hold_valid", out_valid, 1);
      chk("hold_inst", out_inst, exp_inst);
      chk("hold_pc", out_pc, exp_pc);
      chk("hold_busy", busy, 1);
      chk("hold_arvalid", arvalid, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("done_valid", out_valid, 0);
    chk("done_busy", busy, 0);
    step();
    chk("after_busy", busy, 0);
    chk("after_arvalid", arvalid, 0);
`ifdef YSYX_25030093_IFU_PERF_EN
    exp_fetch++;
    if (!mis) begin
      exp_ar += ar_wait;
      exp_r  += r_wait;
    end
    chk("perf_fetch", perf_fetch, exp_fetch);
    chk("perf_ar", perf_ar_stall, exp_ar);
    chk("perf_r", perf_r_stall, exp_r);
`endif
  endtask

  logic [31:0] a;
  logic [1:0]  rsp;

  initial begin
    n_checks = 0;
    n_errors = 0;
`ifdef YSYX_25030093_IFU_PERF_EN
    exp_fetch = 0; exp_ar = 0; exp_r = 0;
`endif
    reset = 1'b1; pc = '0; in_valid_pc = 1'b0; arready = 1'b0;
    rdata = '0; rresp = '0; rvalid = 1'b0; out_ready = 1'b0;
    repeat (3) step();

    // Boot fetch; the PC pulse in the same cycle must be dropped.
    run_fetch(1, 32'h1234_5678, 0, 0, 2'b00, 32'h0000_0413, 0);
    // Stalled address and data phases.
    run_fetch(0, 32'h3000_0004, 2, 3, 2'b00, 32'h0051_0113, 0);
    // Back-pressure in HOLD with an ignored PC pulse.
    run_fetch(0, 32'h3000_0008, 0, 0, 2'b00, 32'h00a0_0093, 4);
    // Error response, then a normal fetch.
    run_fetch(0, 32'h3000_000c, 0, 1, 2'b10, 32'hDEAD_BEEF, 0);
    run_fetch(0, 32'h3000_0010, 1, 0, 2'b00, 32'h0010_0073, 1);
    // Misaligned PC skips the bus.
    run_fetch(0, 32'h3000_0002, 0, 0, 2'b00, 32'h1111_1111, 0);

    // Reset while in DATA; a late rvalid must not be captured.
    in_valid_pc = 1'b1;
    pc          = 32'h3000_0014;
    step();
    in_valid_pc = 1'b0;
    arready     = arvalid;
    step();
    arready = 1'b0;
    chk("mid_rready", rready, 1);
    reset = 1'b1;
    #1;
    chk("rst_rready_now", rready, 0);
    step();
    chk("rst_rready", rready, 0);
    chk("rst_busy", busy, 0);
    rvalid = 1'b1;
    rdata  = 32'hBAD0_BAD0;
    step();
    rvalid = 1'b0;
`ifdef YSYX_25030093_IFU_PERF_EN
    exp_fetch = 0; exp_ar = 0; exp_r = 0;
`endif
    run_fetch(1, 32'h3000_0020, 1, 1, 2'b00, 32'h0000_0513, 0);

    // Randomized fetches.
    for (int t = 0; t < 40; t++) begin
      a = BOOT_PC + ($urandom_range(0, 1023) << 2);
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_fetch(0, a, $urandom_range(0, 3), $urandom_range(0, 3), rsp, $urandom,
                $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_25030093_ifu.md
Name: ysyx_25030093_ifu

Overview:
Instruction fetch unit sitting directly downstream of the PC stage.
- Consumes each new PC plus its one-cycle valid pulse.
- Issues one AXI4-Lite read per PC.
- Presents the fetched instruction, its PC and a fault flag to the decode stage over a valid/ready handshake.
- Performs an autonomous boot fetch at RESET_PC after reset, because the PC stage only pulses valid after writeback.

Parameters:
RESET_PC, 32'h3000_0000, address of the boot fetch issued after reset release.
ADDR_W, 32, address and PC width.

Ports:
clock  input  1  system clock.
reset  input  1  synchronous, active-high reset.
pc  input  32  next PC from the PC stage.
in_valid_pc  input  1  one-cycle pulse; pc is valid this cycle.
busy  output  1  high in any state other than IDLE.
araddr  output  32  AXI read address.
arvalid  output  1  AXI read address valid.
arready  input  1  AXI read address ready.
rdata  input  32  AXI read data.
rresp  input  2  AXI read response.
rvalid  input  1  AXI read data valid.
rready  output  1  AXI read data ready.
out_inst  output  32  fetched instruction.
out_pc  output  32  PC of out_inst.
inst_fault  output  1  fetch fault: rresp != OKAY, or misaligned PC.
out_valid  output  1  out_inst/out_pc/inst_fault valid.
out_ready  input  1  decode stage accepts.

Behaviour:
- Reset is synchronous and active-high. It applies to all states and flops. During reset and on the first cycle after release:
  - state = IDLE; boot_pending = 1.
  - arvalid, rready, out_valid, inst_fault = 0; out_inst = 0; araddr = out_pc = RESET_PC.
- States: IDLE, ADDR, DATA, HOLD.
- IDLE:
  - If boot_pending, latch fetch_pc = RESET_PC and clear boot_pending.
  - Else, if in_valid_pc, latch fetch_pc = pc.
  - If fetch_pc[1:0] != 0, skip the bus: go to HOLD with inst_fault = 1 and out_inst = 0.
  - Otherwise go to ADDR.
- ADDR:
  - arvalid = 1 and araddr = fetch_pc, both held stable until arready.
  - On arready, go to DATA. arvalid drops on the next cycle.
- DATA:
  - rready = 1.
  - On rvalid, capture out_inst = rdata and inst_fault = (rresp != 2'b00), then go to HOLD.
- HOLD:
  - out_valid = 1; out_pc = fetch_pc; outputs held stable.
  - On out_ready, go to IDLE with out_valid = 0 on the next cycle.
- Latency:
  - Best case: in_valid_pc in cycle N gives out_valid in cycle N+3 (arready in N+1, rvalid in N+2).
  - Each wait cycle on arready or rvalid adds one cycle.
- in_valid_pc while not in IDLE is ignored. The PC stage guarantees one outstanding fetch; the bench asserts this.
- in_valid_pc in the same cycle as a pending boot is dropped; the boot fetch wins.
- Reset mid-transaction:
  - Immediate return to IDLE with all outputs at their reset values.
  - An rvalid arriving after reset is not accepted, because rready = 0.
  - The boot fetch re-issues.
- rdata is never sampled outside DATA.
- A fault does not stall the unit. Decode owns the trap.

Optional Feature:
- Macro: YSYX_25030093_IFU_PERF_EN.
- When defined, adds three 64-bit counters, cleared by reset:
  - fetch_cnt: increments on each completed HOLD handshake.
  - ar_stall_cnt: cycles in ADDR with arready = 0.
  - r_stall_cnt: cycles in DATA with rvalid = 0.
- The counters are exposed as output ports perf_fetch, perf_ar_stall and perf_r_stall.
- When not defined, the counters and ports do not exist, and all other behaviour is identical.

Decomposition:
- Shared package ysyx_25030093_pkg holds:
  - the ifu_state_t enum (IDLE/ADDR/DATA/HOLD);
  - the RESP_OKAY = 2'b00 constant;
  - the RESET_PC_DEFAULT constant, shared with the PC stage.
- One natural sub-module: ysyx_25030093_ifu_perf, containing the counters. It is instantiated only under the macro.

Test Plan:
- Reset released, arready = 1, rvalid next cycle with rdata = 32'h00000413 -> araddr = 32'h30000000; out_valid with out_inst = 32'h00000413 and out_pc = 32'h30000000, 3 cycles after release.
- in_valid_pc with pc = 32'h30000004; arready delayed 2 cycles; rvalid delayed 3 cycles -> araddr stable throughout; out_valid at N+8; inst_fault = 0.
- out_ready held low for 4 cycles in HOLD, with in_valid_pc pulsed in between -> out_inst/out_pc stable; pulse ignored; busy = 1; exactly one AR transfer.
- rresp = 2'b10 with rdata = 32'hDEADBEEF -> inst_fault = 1; out_inst = 32'hDEADBEEF; a normal fetch follows.
- pc = 32'h30000002 -> no arvalid ever; out_valid at N+2 with inst_fault = 1 and out_inst = 0.
- reset asserted in DATA, then rvalid one cycle later -> rready = 0 and no capture; boot fetch re-issues at 32'h30000000.
